// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a 16x baud tick derived from sys_clk / CLK_DIV.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits (8E1).
module uart_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start,
  output logic       txd,
  output logic       tx_idle,
  output logic       tx_bits_ok,
  output logic       bps_clk_up_16x
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd4;
`endif

  localparam logic [15:0] DivMax = 16'(CLK_DIV - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        bits_ok_q, bits_ok_d;
  logic        armed_q;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic tick;
  logic bit_end;

  assign tick    = (state_q != StIdle) && (div_q == DivMax);
  assign bit_end = tick && (tick_cnt_q == 4'd15);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    bits_ok_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != StIdle) begin
      div_d = (div_q == DivMax) ? 16'd0 : div_q + 16'd1;
      if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
      end
    end

    case (state_q)
      StIdle: begin
        // armed_q blocks acceptance on the first edge after reset release
        if (tx_start && armed_q) begin
          state_d    = StStart;
          shift_d    = tx_data_i;
          txd_d      = 1'b0;
          div_d      = 16'd0;
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 4'd0;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^tx_data_i;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          txd_d     = shift_q[0];
          bit_cnt_d = 4'd0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == 4'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            txd_d   = parity_q;
`else
            state_d = StStop;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          txd_d   = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          state_d    = StIdle;
          txd_d      = 1'b1;
          bits_ok_d  = 1'b1;
          div_d      = 16'd0;
          tick_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= 16'd0;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      txd_q      <= 1'b1;
      bits_ok_q  <= 1'b0;
      armed_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      bits_ok_q  <= bits_ok_d;
      armed_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign txd            = txd_q;
  assign tx_idle        = (state_q == StIdle);
  assign tx_bits_ok     = bits_ok_q;
  assign bps_clk_up_16x = tick;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, sys_clk cycles per 16x baud tick (legal range 1..65535).
REQ-002 SHALL have port sys_clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tx_data_i  input  8  byte to transmit, sampled only on frame acceptance.
REQ-005 SHALL have port tx_start  input  1  transmit request, level-sampled each cycle.
REQ-006 SHALL have port txd  output  1  serial line, idle high, registered.
REQ-007 SHALL have port tx_idle  output  1  high when no frame in progress and tx_start can be accepted.
REQ-008 SHALL have port tx_bits_ok  output  1  one-cycle pulse marking frame completion.
REQ-009 SHALL have port bps_clk_up_16x  output  1  one-cycle 16x baud tick, for debug and sharing.

Function
REQ-010 SHALL implement states IDLE, START, DATA, STOP (plus PARITY, see REQ-030), one-hot or binary encoding as implementer chooses.
REQ-011 SHALL accept a frame at a rising edge where state=IDLE and tx_start=1, latching tx_data_i into a shift register at that edge.
REQ-012 SHALL ignore tx_start in every state other than IDLE; tx_data_i changes mid-frame SHALL NOT affect the frame.
REQ-013 SHALL clear the tick divider on acceptance, so bit boundaries align to acceptance.
REQ-014 SHALL drive bps_clk_up_16x high for one cycle every CLK_DIV cycles while not IDLE; low in IDLE.
REQ-015 SHALL hold each bit for exactly 16 ticks = 16*CLK_DIV sys_clk cycles (64 at default).
REQ-016 SHALL drive txd=0 (start bit) and tx_idle=0 from the cycle after acceptance.
REQ-017 SHALL send 8 data bits LSB first after the start bit, then one stop bit (txd=1).
REQ-018 SHALL enter IDLE at the end of the stop bit: frame is 10 bit times (640 cycles default) from acceptance+1 to return to IDLE.
REQ-019 SHALL assert tx_bits_ok for exactly the first IDLE cycle after a frame, together with tx_idle=1.
REQ-020 SHALL, if tx_start=1 in that same cycle, accept the next frame there; the line then sees one stop bit plus one sys_clk cycle before the next start bit.
REQ-021 SHALL hold txd=1 at all times in IDLE.
REQ-022 SHALL count bits with a 4-bit counter and ticks with a 4-bit counter; divider width SHALL be 16 bits.

Reset
REQ-023 SHALL, on rst_n=0, immediately (asynchronously) force state=IDLE, txd=1, tx_idle=1, tx_bits_ok=0, bps_clk_up_16x=0, all counters and shift register to 0.
REQ-024 SHALL abort any in-progress frame on reset without emitting tx_bits_ok.
REQ-025 SHALL not accept tx_start in the cycle rst_n is released; acceptance is possible from the next rising edge.

Configuration
REQ-030 SHALL, with macro UART_TX_PARITY_EN defined, insert a PARITY state after DATA sending one even-parity bit (XOR of 8 data bits) for 16 ticks; frame = 11 bit times (704 cycles default).
REQ-031 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and logic entirely; frame = 10 bit times.

Verification
REQ-040 Reset, tx_start pulse with tx_data_i=8'hF0 -> txd = 0,0,0,0,0,1,1,1,1,1 each 64 cycles, tx_bits_ok pulse 640 cycles after start-bit onset.
REQ-041 tx_start held high with 8'hB8 then 8'h12 -> two frames, 1-cycle gap beyond stop bit, bits 0,0,0,0,1,1,1,0,1,1 then 0,0,1,0,0,1,0,0,0,1.
REQ-042 tx_start pulsed and tx_data_i changed to 8'hFF mid-frame of 8'h3C -> 8'h3C sent unchanged, second tx_start ignored, exactly one tx_bits_ok.
REQ-043 rst_n low for 5 cycles during bit 3 of 8'hA5 -> txd=1 within same cycle, tx_idle=1, no tx_bits_ok; next frame 8'h5A sent correctly.
REQ-044 UART_TX_PARITY_EN defined, 8'h12 then 8'h3D -> parity bits 0 then 1, frames 704 cycles each.
REQ-045 Loopback txd into uart_rx at CLK_DIV=4 -> received rx_data_o matches each of 8'hF0, 8'hB8, 8'h12, 8'h3D.
